// File: rtl/mem_bus_stage_pkg.sv
// Shared types, widths and op codes for the MEM stage and its data-bus path.
package mem_bus_stage_pkg;

    localparam int unsigned REG_BUS_W  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned STALL_W    = 6;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic                  STOP         = 1'b1;
    localparam logic                  NO_STOP      = 1'b0;

    localparam logic [ALUOP_W-1:0] OP_LB  = 8'hE0;
    localparam logic [ALUOP_W-1:0] OP_LBU = 8'hE4;
    localparam logic [ALUOP_W-1:0] OP_LH  = 8'hE1;
    localparam logic [ALUOP_W-1:0] OP_LHU = 8'hE5;
    localparam logic [ALUOP_W-1:0] OP_LW  = 8'hE3;
    localparam logic [ALUOP_W-1:0] OP_SB  = 8'hE8;
    localparam logic [ALUOP_W-1:0] OP_SH  = 8'hE9;
    localparam logic [ALUOP_W-1:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } mem_state_e;

    // Registered data-bus command held stable while a request is outstanding.
    typedef struct packed {
        logic                 we;
        logic [REG_BUS_W-1:0] addr;
        logic [SEL_W-1:0]     sel;
        logic [REG_BUS_W-1:0] wdata;
    } dbus_cmd_t;

    function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_bus_stage_align.sv
// Big-endian byte-lane select, store replication and load extract/extend.
// Purely combinational so the same block can serve a cache return path.
module mem_align
    import mem_bus_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0]   aluop,
    input  logic [1:0]           byte_off,
    input  logic [REG_BUS_W-1:0] store_data,
    input  logic [REG_BUS_W-1:0] rdata,
    output logic [SEL_W-1:0]     sel_c,
    output logic [REG_BUS_W-1:0] wdata_c,
    output logic [REG_BUS_W-1:0] load_data_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    // Lane extraction: byte 0 of the word lives in bits [31:24].
    always_comb begin
        rbyte = rdata[7:0];
        case (byte_off)
            2'b00:   rbyte = rdata[31:24];
            2'b01:   rbyte = rdata[23:16];
            2'b10:   rbyte = rdata[15:8];
            default: rbyte = rdata[7:0];
        endcase
        rhalf    = byte_off[1] ? rdata[15:0] : rdata[31:16];
        byte_sel = 4'b1000 >> byte_off;
        half_sel = byte_off[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel_c       = '0;
        wdata_c     = ZERO_WORD;
        load_data_c = ZERO_WORD;
        case (aluop)
            OP_LB: begin
                sel_c       = byte_sel;
                load_data_c = {{24{rbyte[7]}}, rbyte};
            end
            OP_LBU: begin
                sel_c       = byte_sel;
                load_data_c = {24'h0, rbyte};
            end
            OP_LH: begin
                sel_c       = half_sel;
                load_data_c = {{16{rhalf[15]}}, rhalf};
            end
            OP_LHU: begin
                sel_c       = half_sel;
                load_data_c = {16'h0, rhalf};
            end
            OP_LW: begin
                sel_c       = 4'b1111;
                load_data_c = rdata;
            end
            OP_SB: begin
                sel_c   = byte_sel;
                wdata_c = {4{store_data[7:0]}};
            end
            OP_SH: begin
                sel_c   = half_sel;
                wdata_c = {2{store_data[15:0]}};
            end
            OP_SW: begin
                sel_c   = 4'b1111;
                wdata_c = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: result pass-through plus a req/ack data-bus transaction.
// Optional ack timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_stage
    import mem_bus_stage_pkg::*;
`ifdef MEM_BUS_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic [REG_BUS_W-1:0]  mem_wdata_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic                  mem_wreg_i,
    input  logic                  mem_whilo_i,
    input  logic [REG_BUS_W-1:0]  mem_hi_i,
    input  logic [REG_BUS_W-1:0]  mem_lo_i,
    input  logic [ALUOP_W-1:0]    mem_aluop_i,
    input  logic [REG_BUS_W-1:0]  mem_addr_i,
    input  logic [REG_BUS_W-1:0]  mem_reg2_i,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [REG_BUS_W-1:0]  dbus_addr_o,
    output logic [REG_BUS_W-1:0]  dbus_wdata_o,
    output logic [SEL_W-1:0]      dbus_sel_o,
    input  logic [REG_BUS_W-1:0]  dbus_rdata_i,
    input  logic                  dbus_ack_i,
    output logic                  stallreq_o,
    output logic [REG_BUS_W-1:0]  wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  whilo_o,
    output logic [REG_BUS_W-1:0]  hi_o,
    output logic [REG_BUS_W-1:0]  lo_o,
    output logic                  bus_err_o
);

    mem_state_e           state;
    dbus_cmd_t            cmd_q;
    logic [REG_BUS_W-1:0] buf_q;

    logic                 load_op;
    logic                 store_op;
    logic                 mem_op;
    logic                 timeout_c;
    logic                 done_c;
    logic [REG_BUS_W-1:0] rdata_c;
    logic [SEL_W-1:0]     sel_c;
    logic [REG_BUS_W-1:0] st_data_c;
    logic [REG_BUS_W-1:0] ld_data_c;

    assign load_op  = is_load_op(mem_aluop_i);
    assign store_op = is_store_op(mem_aluop_i);
    assign mem_op   = load_op | store_op;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts BUSY cycles; held at zero outside BUSY so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (state != ST_BUSY)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_c = (state == ST_BUSY) && !dbus_ack_i &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = timeout_c && !rst;
`else
    assign timeout_c = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // A timeout completes the transaction as if acked with all-zero data.
    assign done_c  = (state == ST_BUSY) && (dbus_ack_i || timeout_c);
    assign rdata_c = timeout_c ? ZERO_WORD : dbus_rdata_i;

    mem_align u_align (
        .aluop       (mem_aluop_i),
        .byte_off    (mem_addr_i[1:0]),
        .store_data  (mem_reg2_i),
        .rdata       (rdata_c),
        .sel_c       (sel_c),
        .wdata_c     (st_data_c),
        .load_data_c (ld_data_c)
    );

    assign dbus_we_o    = cmd_q.we;
    assign dbus_addr_o  = cmd_q.addr;
    assign dbus_sel_o   = cmd_q.sel;
    assign dbus_wdata_o = cmd_q.wdata;

    // Transaction FSM with registered bus command and load buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dbus_req_o <= 1'b0;
            cmd_q      <= '0;
            buf_q      <= ZERO_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        dbus_req_o  <= 1'b1;
                        cmd_q.we    <= store_op;
                        cmd_q.addr  <= {mem_addr_i[REG_BUS_W-1:2], 2'b00};
                        cmd_q.sel   <= sel_c;
                        cmd_q.wdata <= st_data_c;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_c) begin
                        dbus_req_o <= 1'b0;
                        cmd_q      <= '0;
                        if (load_op) begin
                            buf_q <= ld_data_c;
                        end
                        state <= (stall == '0) ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stall == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result path: pass-through except for loads that are waiting or parked.
    always_comb begin
        stallreq_o = NO_STOP;
        wdata_o    = mem_wdata_i;
        wd_o       = mem_wd_i;
        wreg_o     = mem_wreg_i;
        whilo_o    = mem_whilo_i;
        hi_o       = mem_hi_i;
        lo_o       = mem_lo_i;
        if (rst) begin
            wdata_o = ZERO_WORD;
            wd_o    = NOP_REG_ADDR;
            wreg_o  = 1'b0;
            whilo_o = 1'b0;
            hi_o    = ZERO_WORD;
            lo_o    = ZERO_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        stallreq_o = STOP;
                    end
                    if (load_op) begin
                        wdata_o = buf_q;
                        wreg_o  = 1'b0;
                    end
                end
                ST_BUSY: begin
                    stallreq_o = done_c ? NO_STOP : STOP;
                    if (load_op) begin
                        wdata_o = done_c ? ld_data_c : buf_q;
                        wreg_o  = done_c ? mem_wreg_i : 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (load_op) begin
                        wdata_o = buf_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Directed bench for mem_bus_stage with a transaction-level reference model.
module tb_mem_bus_stage;

    localparam logic [7:0] LB  = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
    localparam logic [7:0] SB  = 8'hE8, SH  = 8'hE9, SW = 8'hEB, NOP_OP = 8'h21;

    logic        clk, rst;
    logic [5:0]  stall;
    logic [31:0] mem_wdata_i, mem_hi_i, mem_lo_i, mem_addr_i, mem_reg2_i;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i, mem_whilo_i;
    logic [7:0]  mem_aluop_i;
    logic        dbus_req_o, dbus_we_o, dbus_ack_i;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic [3:0]  dbus_sel_o;
    logic        stallreq_o, wreg_o, whilo_o, bus_err_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic [4:0]  wd_o;

    int errors = 0;
    int checks = 0;

    mem_bus_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wdata_i(mem_wdata_i), .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_sel_o(dbus_sel_o),
        .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
        .stallreq_o(stallreq_o), .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_ld(input logic [7:0] op);
        return op == LB || op == LBU || op == LH || op == LHU || op == LW;
    endfunction

    function automatic logic is_st(input logic [7:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int          sh;
        logic [31:0] v;
        v = 32'h0;
        if (op == LB || op == LBU) begin
            sh = 8 * (3 - int'(addr[1:0]));
            v  = (rd >> sh) & 32'h0000_00FF;
            if (op == LB && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op == LH || op == LHU) begin
            sh = addr[1] ? 0 : 16;
            v  = (rd >> sh) & 32'h0000_FFFF;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        end else if (op == LW) begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
        if (op == LB || op == LBU || op == SB) return 4'(1 << (3 - int'(addr[1:0])));
        if (op == LH || op == LHU || op == SH) return addr[1] ? 4'b0011 : 4'b1100;
        if (op == LW || op == SW) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] reg2);
        if (op == SB) return 32'(reg2[7:0]) * 32'h0101_0101;
        if (op == SH) return 32'(reg2[15:0]) * 32'h0001_0001;
        return reg2;
    endfunction

    // Reference model: an outstanding bus command, and a parked load result.
    logic        cmp_on = 1'b0;
    logic        outstanding = 1'b0, parked = 1'b0;
    logic [31:0] held = 32'h0, m_addr = 32'h0, m_wdata = 32'h0;
    logic [3:0]  m_sel = 4'h0;
    logic        m_we = 1'b0;
    int          wait_n = 0;
    logic        eff_ack, exp_err, ld, exp_stall;
    logic [31:0] eff_rd;

    always @(negedge clk) begin
        if (cmp_on) begin
            ld      = is_ld(mem_aluop_i);
            eff_ack = outstanding && dbus_ack_i;
            eff_rd  = dbus_rdata_i;
            exp_err = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            if (outstanding && !dbus_ack_i && wait_n == 15) begin
                eff_ack = 1'b1;
                eff_rd  = 32'h0;
                exp_err = 1'b1;
            end
`endif
            if (rst) exp_err = 1'b0;
            chk("m_req", 32'(dbus_req_o), 32'(outstanding));
            if (outstanding) begin
                chk("m_we", 32'(dbus_we_o), 32'(m_we));
                chk("m_addr", dbus_addr_o, m_addr);
                chk("m_sel", 32'(dbus_sel_o), 32'(m_sel));
                if (m_we) chk("m_bus_wdata", dbus_wdata_o, m_wdata);
            end
            chk("m_bus_err", 32'(bus_err_o), 32'(exp_err));
            if (rst) begin
                chk("m_rst_stallreq", 32'(stallreq_o), 32'h0);
                chk("m_rst_wdata", wdata_o, 32'h0);
                chk("m_rst_wd", 32'(wd_o), 32'h0);
                chk("m_rst_wreg", 32'(wreg_o), 32'h0);
                chk("m_rst_hi", hi_o, 32'h0);
                chk("m_rst_lo", lo_o, 32'h0);
            end else begin
                exp_stall = outstanding ? !eff_ack
                          : (parked ? 1'b0 : (ld || is_st(mem_aluop_i)));
                chk("m_stallreq", 32'(stallreq_o), 32'(exp_stall));
                chk("m_wd", 32'(wd_o), 32'(mem_wd_i));
                chk("m_whilo", 32'(whilo_o), 32'(mem_whilo_i));
                chk("m_hi", hi_o, mem_hi_i);
                chk("m_lo", lo_o, mem_lo_i);
                if (ld && outstanding) begin
                    chk("m_ld_wdata", wdata_o,
                        eff_ack ? ref_load(mem_aluop_i, mem_addr_i, eff_rd) : held);
                    chk("m_ld_wreg", 32'(wreg_o), eff_ack ? 32'(mem_wreg_i) : 32'h0);
                end else if (ld && parked) begin
                    chk("m_park_wdata", wdata_o, held);
                    chk("m_park_wreg", 32'(wreg_o), 32'(mem_wreg_i));
                end else if (ld) begin
                    chk("m_idle_ld_wreg", 32'(wreg_o), 32'h0);
                end else begin
                    chk("m_wdata", wdata_o, mem_wdata_i);
                    chk("m_wreg", 32'(wreg_o), 32'(mem_wreg_i));
                end
            end
            // advance the model to the state after the coming edge
            if (rst) begin
                outstanding = 1'b0;
                parked      = 1'b0;
                held        = 32'h0;
            end else if (outstanding) begin
                if (eff_ack) begin
                    outstanding = 1'b0;
                    if (ld) held = ref_load(mem_aluop_i, mem_addr_i, eff_rd);
                    parked = (stall != 6'b0);
                end else begin
                    wait_n++;
                end
            end else if (parked) begin
                if (stall == 6'b0) parked = 1'b0;
            end else if (ld || is_st(mem_aluop_i)) begin
                outstanding = 1'b1;
                wait_n      = 0;
                m_we        = is_st(mem_aluop_i);
                m_addr      = mem_addr_i & 32'hFFFF_FFFC;
                m_sel       = ref_sel(mem_aluop_i, mem_addr_i);
                m_wdata     = ref_wdata(mem_aluop_i, mem_reg2_i);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
        mem_aluop_i = op;
        mem_addr_i  = addr;
        mem_reg2_i  = reg2;
        mem_wdata_i = wdata;
        mem_wd_i    = wd;
        mem_wreg_i  = wreg;
        mem_whilo_i = ~wreg;
        mem_hi_i    = ~wdata;
        mem_lo_i    = wdata ^ 32'h0F0F_0F0F;
    endtask

    task automatic one_load(input string name, input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [3:0] exp_sel,
                            input logic [31:0] exp_data);
        drive(op, addr, 32'h0, 32'hCAFE_0000, 5'd7, 1'b1);
        next();
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = rd;
        @(negedge clk);
        chk({name, "_sel"}, 32'(dbus_sel_o), 32'(exp_sel));
        chk({name, "_data"}, wdata_o, exp_data);
        next();
        dbus_ack_i = 1'b0;
    endtask

    task automatic one_store(input string name, input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] reg2, input logic [3:0] exp_sel,
                             input logic [31:0] exp_bus, input logic [31:0] exp_addr);
        drive(op, addr, reg2, 32'h0000_0202, 5'd9, 1'b0);
        next();
        dbus_ack_i = 1'b1;
        @(negedge clk);
        chk({name, "_we"}, 32'(dbus_we_o), 32'h1);
        chk({name, "_sel"}, 32'(dbus_sel_o), 32'(exp_sel));
        chk({name, "_bus_wdata"}, dbus_wdata_o, exp_bus);
        chk({name, "_addr"}, dbus_addr_o, exp_addr);
        next();
        dbus_ack_i = 1'b0;
    endtask

    int req_cycles;
    int n;
    logic seen;

    initial begin
        rst = 1'b1;
        stall = 6'b0;
        dbus_ack_i = 1'b0;
        dbus_rdata_i = 32'h0;
        drive(NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        next();
        cmp_on = 1'b1;
        drive(NOP_OP, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd31, 1'b1);
        @(negedge clk);
        chk("rst_wd", 32'(wd_o), 32'h0);
        chk("rst_req", 32'(dbus_req_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        next();
        rst = 1'b0;

        // non-memory op passes straight through
        drive(NOP_OP, 32'h40, 32'h0, 32'h1234_5678, 5'd5, 1'b1);
        @(negedge clk);
        chk("nop_wdata", wdata_o, 32'h1234_5678);
        chk("nop_wd", 32'(wd_o), 32'h5);
        chk("nop_wreg", 32'(wreg_o), 32'h1);
        chk("nop_req", 32'(dbus_req_o), 32'h0);
        chk("nop_stallreq", 32'(stallreq_o), 32'h0);
        next();

        // LW acked in the third request cycle
        drive(LW, 32'h100, 32'h0, 32'h5555_5555, 5'd3, 1'b1);
        @(negedge clk);
        chk("lw_idle_stallreq", 32'(stallreq_o), 32'h1);
        next();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                dbus_ack_i   = 1'b1;
                dbus_rdata_i = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (dbus_req_o) req_cycles++;
            chk("lw_sel", 32'(dbus_sel_o), 32'hF);
            if (i < 2) begin
                chk("lw_wait_stallreq", 32'(stallreq_o), 32'h1);
            end else begin
                chk("lw_ack_stallreq", 32'(stallreq_o), 32'h0);
                chk("lw_ack_wdata", wdata_o, 32'hDEAD_BEEF);
                chk("lw_ack_wreg", 32'(wreg_o), 32'h1);
            end
            next();
        end
        dbus_ack_i = 1'b0;
        chk("lw_req_cycles", 32'(req_cycles), 32'h3);

        // back-to-back loads covering lanes, extension and ignored address bits
        one_load("lb",  LB,  32'h101, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
        one_load("lbu", LBU, 32'h101, 32'h0080_0000, 4'b0100, 32'h0000_0080);
        one_load("lb3", LB,  32'h103, 32'h0000_007F, 4'b0001, 32'h0000_007F);
        one_load("lh2", LH,  32'h102, 32'h1234_8765, 4'b0011, 32'hFFFF_8765);
        one_load("lh1", LH,  32'h101, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        one_load("lw3", LW,  32'h107, 32'h0102_0304, 4'b1111, 32'h0102_0304);

        one_store("sh", SH, 32'h202, 32'h0000_ABCD, 4'b0011, 32'hABCD_ABCD, 32'h200);
        one_store("sb", SB, 32'h203, 32'h1234_5678, 4'b0001, 32'h7878_7878, 32'h200);
        one_store("sw", SW, 32'h20E, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F, 32'h20C);

        // LHU acked while the pipeline is stalled: result parked until stall clears
        drive(LHU, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1);
        next();
        stall = 6'b001111;
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h1234_8765;
        @(negedge clk);
        chk("lhu_ack_wdata", wdata_o, 32'h0000_8765);
        next();
        dbus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("lhu_hold1_wdata", wdata_o, 32'h0000_8765);
        chk("lhu_hold1_stallreq", 32'(stallreq_o), 32'h0);
        chk("lhu_hold1_req", 32'(dbus_req_o), 32'h0);
        next();
        dbus_ack_i = 1'b0;
        @(negedge clk);
        chk("lhu_hold2_wdata", wdata_o, 32'h0000_8765);
        next();
        stall = 6'b0;
        @(negedge clk);
        chk("lhu_hold3_wdata", wdata_o, 32'h0000_8765);
        next();
        drive(LW, 32'h500, 32'h0, 32'h0, 5'd6, 1'b1);
        @(negedge clk);
        chk("post_hold_stallreq", 32'(stallreq_o), 32'h1);
        next();
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h0000_1111;
        @(negedge clk);
        chk("post_hold_req", 32'(dbus_req_o), 32'h1);
        next();
        dbus_ack_i = 1'b0;

        // reset while BUSY drops the request; a late ack is ignored
        drive(LW, 32'h300, 32'h0, 32'h0, 5'd8, 1'b1);
        next();
        @(negedge clk);
        chk("rb_busy_req", 32'(dbus_req_o), 32'h1);
        next();
        rst = 1'b1;
        @(negedge clk);
        chk("rb_rst_stallreq", 32'(stallreq_o), 32'h0);
        next();
        rst = 1'b0;
        drive(NOP_OP, 32'h0, 32'h0, 32'h3333_4444, 5'd2, 1'b1);
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h1111_1111;
        @(negedge clk);
        chk("rb_req", 32'(dbus_req_o), 32'h0);
        chk("rb_stallreq", 32'(stallreq_o), 32'h0);
        chk("rb_wdata", wdata_o, 32'h3333_4444);
        next();
        dbus_ack_i = 1'b0;
        @(negedge clk);
        chk("rb_req_after", 32'(dbus_req_o), 32'h0);
        next();

        drive(LW, 32'h400, 32'h0, 32'h0, 5'd2, 1'b1);
        next();
`ifdef MEM_BUS_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus_err_o) begin
                seen = 1'b1;
                chk("to_wdata", wdata_o, 32'h0);
            end
            next();
        end
        chk("to_cycles", 32'(n), 32'd16);
        drive(NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
`else
        // without the timeout the request waits as long as the ack takes
        repeat (20) next();
        @(negedge clk);
        chk("wait_req", 32'(dbus_req_o), 32'h1);
        chk("wait_stallreq", 32'(stallreq_o), 32'h1);
        next();
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        chk("wait_data", wdata_o, 32'h0BAD_F00D);
        next();
        dbus_ack_i = 1'b0;
        drive(NOP_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
`endif
        repeat (3) next();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_stage.md
Name: mem_bus_stage

Overview:
- MEM pipeline stage. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Passes ALU and HI/LO results through unchanged.
- For load/store ops, runs a req/ack transaction on the data bus through a small FSM, requesting a pipeline stall until the bus acknowledges.
- Aligns and extends load data; generates byte-lane selects for stores (big-endian).

Parameters:
- TIMEOUT_CYCLES, 16: ack wait limit; used only when MEM_BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  6  pipeline stall vector from controller; bit 4 = MEM stage
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_wd_i  in  5  destination register address
- mem_wreg_i  in  1  register write enable
- mem_whilo_i  in  1  HI/LO write enable
- mem_hi_i  in  32  HI value
- mem_lo_i  in  32  LO value
- mem_aluop_i  in  8  operation code
- mem_addr_i  in  32  effective address
- mem_reg2_i  in  32  store data
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write
- dbus_addr_o  out  32  word address {addr[31:2],2'b00}
- dbus_wdata_o  out  32  store data, replicated across lanes
- dbus_sel_o  out  4  byte-lane select
- dbus_rdata_i  in  32  read data
- dbus_ack_i  in  1  single-cycle acknowledge
- stallreq_o  out  1  stall request to controller
- wdata_o  out  32  result to MEM/WB
- wd_o  out  5  destination register address to MEM/WB
- wreg_o  out  1  register write enable to MEM/WB
- whilo_o  out  1  HI/LO write enable to MEM/WB
- hi_o  out  32  HI value to MEM/WB
- lo_o  out  32  LO value to MEM/WB
- bus_err_o  out  1  bus timeout pulse (MEM_BUS_TIMEOUT_EN only)

Behaviour:
- Reset:
  - FSM to IDLE.
  - dbus_req_o, dbus_we_o, dbus_sel_o, dbus_addr_o, dbus_wdata_o all 0.
  - Data buffer cleared to 0.
  - Result outputs 0; wd_o = 0.
  - stallreq_o = 0.
  - Reset mid-transaction abandons the transaction immediately. The bus must tolerate a dropped req.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. All other aluop values are non-memory.
- Non-memory op in IDLE:
  - All result outputs equal their inputs, combinationally.
  - No bus activity; stallreq_o = 0.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: if the op is a memory op, assert stallreq_o combinationally. At the next edge, register req=1 with we/addr/sel/wdata, then go to BUSY.
  - BUSY: hold req and all bus fields stable. stallreq_o = !dbus_ack_i.
  - BUSY, on ack: drop req at the edge and capture the aligned/extended load word into the buffer.
    - If stall == 6'b0 at the ack cycle, go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: stallreq_o = 0. Load results are driven from the buffer. Go to IDLE at the first edge where stall == 0.
- Result outputs for a load:
  - wdata_o = ack ? aligned(dbus_rdata_i) : buffer in the ack cycle; buffer in HOLD.
  - wreg_o passes mem_wreg_i.
  - During BUSY before ack, wreg_o = 0.
- Stores: wdata_o = mem_wdata_i; wreg_o = mem_wreg_i.
- Byte lanes (big-endian):
  - Byte: addr[1:0] = 00/01/10/11 -> sel 1000/0100/0010/0001; byte taken from [31:24]/[23:16]/[15:8]/[7:0].
  - Half: addr[1] = 0 -> sel 1100, bits [31:16]; addr[1] = 1 -> sel 0011, bits [15:0]. addr[0] is ignored.
  - Word: sel 1111; addr[1:0] is ignored.
  - No alignment exception is raised.
- Extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Store data: SB = {4{reg2[7:0]}}, SH = {2{reg2[15:0]}}, SW = reg2.
- Back-to-back memory ops: a second op is accepted in IDLE only.
- ack while in IDLE or HOLD is ignored.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY, cleared on entry to BUSY.
  - When the count reaches TIMEOUT_CYCLES without ack: drop req, pulse bus_err_o for 1 cycle, treat as ack with rdata = 0, and follow the normal ack transitions.
- Not defined: BUSY waits indefinitely; bus_err_o is tied to 0.

Decomposition:
- Shared package / defines:
  - RegBus, RegAddrBus, ZeroWord, NOPRegAddr, Stop/NoStop.
  - The eight load/store aluop codes (LB 8'hE0, LBU 8'hE4, LH 8'hE1, LHU 8'hE5, LW 8'hE3, SB 8'hE8, SH 8'hE9, SW 8'hEB).
  - FSM state encoding.
- One sub-module, mem_align: combinational lane select, store replication and load extract/extend. It is reused by a future cache path.

Test Plan:
- Reset then non-memory op (wdata 32'h1234_5678, wd 5, wreg 1) -> same values on outputs that cycle; req = 0; stallreq = 0.
- LW at addr 32'h100, ack after 3 cycles with rdata 32'hDEAD_BEEF:
  - req high for 3 cycles with sel 1111;
  - stallreq high until the ack cycle;
  - wdata_o = 32'hDEAD_BEEF, wreg_o = 1 in the ack cycle.
- LB at addr 32'h101 with rdata 32'h0080_0000 -> sel 0100, wdata_o = 32'hFFFF_FF80. Same stimulus as LBU -> wdata_o = 32'h0000_0080.
- SH at addr 32'h202 with reg2 32'h0000_ABCD -> we = 1, sel 0011, dbus_wdata = 32'hABCD_ABCD, addr = 32'h200.
- LHU ack while stall = 6'b001111 held 2 more cycles -> FSM in HOLD; wdata_o holds the buffered value through both cycles; returns to IDLE when stall = 0.
- Reset asserted in BUSY -> req = 0 next edge; FSM in IDLE; later ack ignored. With MEM_BUS_TIMEOUT_EN and no ack: bus_err_o pulses after 16 cycles and wdata_o = 0.
